aes_encryption: RTL and testbench
=================================

# aes_encryption

Iterative AES-128 encryption core, one round per clock, forming the transmit-side counterpart of the AES decryption pipeline. It accepts a 128-bit plaintext block through a valid/ready handshake and reads round keys 1..10 from the shared round-key store through an address/data port. Round key 0 arrives on a dedicated input. It presents the ciphertext through a second valid/ready handshake, holding it until the result is consumed.

## Interface
- No parameters. Fixed at AES-128, 10 rounds.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  a plaintext block is available on in_data.
- in_ready  out  1  core can accept a block. High only in IDLE.
- in_data  in  128  plaintext. Byte 0 is bits [127:120], column-major state per FIPS-197.
- round_key_0  in  128  initial whitening key, stable while the core is not IDLE.
- round_key_addr  out  4  index of the round key needed this cycle: 1..10 in ROUND, 0 otherwise.
- round_key_input  in  128  key-store read data for round_key_addr, combinational in the same cycle.
- out_valid  out  1  ciphertext valid on out_data.
- out_ready  in  1  consumer accepts the ciphertext.
- out_data  out  128  ciphertext. Same byte order as in_data.
- busy  out  1  high in ROUND or DONE.

## Operation
- Registers:
  - state block: 128 bits.
  - round counter: 4 bits.
  - FSM: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: block <= in_data ^ round_key_0; round <= 1; go to ROUND.
- ROUND:
  - round_key_addr = round.
  - Each cycle: block <= AddRoundKey(MixColumns(ShiftRows(SubBytes(block))), round_key_input).
  - MixColumns is bypassed when round == 10.
  - If round == 10: go to DONE; otherwise round <= round + 1.
- DONE:
  - out_valid=1 and out_data=block. Both are held stable while out_ready=0.
  - On out_ready: go to IDLE, and out_valid drops on the next edge.
- out_data equals the block register in every state. Its value is only meaningful while out_valid=1.
- in_valid outside IDLE is ignored. No block is captured, and no data is lost provided the producer honours in_ready.
- Combinational round datapath uses the forward S-box (FIPS-197 table) and MixColumns over GF(2^8) with polynomial 0x11B.
- Arithmetic is XOR/GF only: no carries, all widths 128 bits, round counter never exceeds 10.
- Reset behaviour, at any time including mid-round or in DONE:
  - FSM goes to IDLE, block=0, round=0.
  - in_ready=1, out_valid=0, busy=0, round_key_addr=0, out_data=0.
  - A partially processed block is discarded.

## Timing
- Let edge E0 be the edge that completes the input handshake.
- Edges E1..E10 execute rounds 1..10. round_key_addr=k is driven during the cycle before edge Ek.
- out_valid is high after E10: 10 cycles from acceptance to valid.
- With out_ready held high, out_valid is high for exactly 1 cycle and in_ready returns after E11.
- The earliest next acceptance is at E12. Minimum block period is 12 cycles.
- out_ready asserted before DONE has no effect.
- in_valid and out_ready asserted in the same DONE cycle: the output is consumed, the input is not accepted until IDLE.
- round_key_input must settle within the same cycle as round_key_addr. No key-read latency is tolerated.

## Test plan
- FIPS-197 C.1 vector:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff, out_ready=1.
  - Required response: out_data=69c4e0d86a7b0430d8cdb78070b4c55a, with out_valid exactly 10 cycles after acceptance.
  - Required response: round_key_addr sequence 1,2,…,10.
- FIPS-197 Appendix B vector:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734.
  - Required response: out_data=3925841d02dc09fbdc118597196a0b32.
  - Required response: round_key_input at addr 10 equals d014f9a8c9ee2589e13f0cc8b6630ca6.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles after out_valid.
  - Required response: out_valid and out_data stay stable, in_ready=0, busy=1.
  - Stimulus: raise out_ready for 1 cycle.
  - Required response: IDLE on the next edge.
- Input while busy:
  - Stimulus: hold in_valid=1 with a different plaintext throughout ROUND/DONE.
  - Required response: first ciphertext is unchanged, second block is accepted only at the first IDLE edge, and the second ciphertext is correct.
  - Required response: the two acceptances are ≥12 cycles apart.
- Reset mid-round:
  - Stimulus: assert rst at round 5.
  - Required response: outputs go immediately to in_ready=1, out_valid=0, busy=0, round_key_addr=0, out_data=0.
  - Stimulus: encrypt the C.1 vector after release.
  - Required response: correct result.
- Back-to-back stream:
  - Stimulus: 4 random blocks and keys, with random out_ready stalls.
  - Required response: every ciphertext matches a reference model and none are dropped or duplicated.

Source files
------------

// File: rtl/aes_encryption.sv
// aes_encryption: iterative AES-128 encryptor, one round per clock.
// The plaintext is whitened with round key 0 at acceptance; keys 1..10 are read from an external store.
module aes_encryption (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] round_key_0,
  output logic [3:0]   round_key_addr,
  input  logic [127:0] round_key_input,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
  state_t       r_state;
  logic [127:0] r_block;
  logic [3:0]   r_round;
  logic         r_in_ready, r_out_valid, r_busy;
  logic [127:0] w_sr, w_mc, w_next;
  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [31:0] mix(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3, a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3, xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction
  // Byte 4c+r sits at row r, column c; ShiftRows pulls row r from column c+r.
  always_comb begin
    w_sr = '0;
    w_mc = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++)
        w_sr[127-8*(4*c+r) -: 8] = sb(r_block[127-8*(4*((c+r)%4)+r) -: 8]);
      w_mc[127-32*c -: 32] = mix(w_sr[127-32*c -: 32]);
    end
    w_next = ((r_round == 4'd10) ? w_sr : w_mc) ^ round_key_input;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_block     <= '0;
      r_round     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_block    <= in_data ^ round_key_0;
          r_round    <= 4'd1;
          r_state    <= ROUND;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b1;
        end
        ROUND: begin
          r_block <= w_next;
          if (r_round == 4'd10) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end else r_round <= r_round + 4'd1;
        end
        DONE: if (out_ready) begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign in_ready       = r_in_ready;
  assign out_valid      = r_out_valid;
  assign busy           = r_busy;
  assign out_data       = r_block;
  assign round_key_addr = (r_state == ROUND) ? r_round : 4'd0;
endmodule

// File: tb/tb_aes_encryption.sv
// tb_aes_encryption: scoreboard bench for the iterative AES-128 encryptor.
// Reference S-box and key schedule are derived arithmetically from GF(2^8).
module tb_aes_encryption;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [127:0] in_data = '0, round_key_0, round_key_input, out_data;
  logic in_ready, out_valid, busy;
  logic [3:0] round_key_addr;
  logic [127:0] rk [0:10];
  logic [7:0] sbox_t [0:255];
  logic [127:0] exp_q [$];
  int n_tests = 0, n_fail = 0;
  localparam logic [127:0] K_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes_encryption dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .round_key_0(round_key_0), .round_key_addr(round_key_addr), .round_key_input(round_key_input),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy));

  always #5 clk = ~clk;
  assign round_key_0 = rk[0];
  always_comb round_key_input = rk[(round_key_addr > 4'd10) ? 4'd0 : round_key_addr];

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00, x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic init_sbox();
    logic [7:0] b;
    for (int x = 0; x < 256; x++) begin
      b = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      sbox_t[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  task automatic set_key(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] model_enc(input logic [127:0] pt);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[0][127-8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) s[4*c+w] = t[4*((c+w)%4)+w];
      if (r < 10)
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
          s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
        end
      for (int i = 0; i < 16; i++) s[i] ^= rk[r][127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if ({in_ready, out_valid, busy, round_key_addr, out_data} !== {3'b100, 4'd0, 128'd0}) begin
      n_fail++;
      $display("FAIL reset_outputs got rdy=%b vld=%b busy=%b addr=%0d data=%h", in_ready, out_valid, busy, round_key_addr, out_data);
    end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_fips_c1();
    int lat = -1;
    set_key(K_C1);
    out_ready = 1;
    in_data = P_C1;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL c1_in_ready got=%b exp=1", in_ready); end
    in_valid = 1;
    exp_q.push_back(model_enc(P_C1));
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      in_valid = 0;
      if (out_valid) begin lat = c; break; end
      n_tests++;
      if (round_key_addr !== 4'(c + 1)) begin n_fail++; $display("FAIL c1_addr step %0d got=%0d exp=%0d", c, round_key_addr, c + 1); end
    end
    n_tests++;
    if (lat != 10) begin n_fail++; $display("FAIL c1_latency got=%0d exp=10", lat); end
    n_tests++;
    if (out_data !== C_C1) begin n_fail++; $display("FAIL c1_vector got=%h exp=%h", out_data, C_C1); end
    n_tests++;
    if (exp_q.size() == 0 || out_data !== exp_q[0]) begin n_fail++; $display("FAIL c1_scoreboard got=%h", out_data); end
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    @(negedge clk);
    n_tests++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin n_fail++; $display("FAIL c1_one_cycle_valid got vld/rdy/busy=%b exp=010", {out_valid, in_ready, busy}); end
  endtask

  task automatic test_backpressure();
    logic [127:0] held;
    set_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    out_ready = 0;
    in_data = 128'h3243f6a8885a308d313198a2e0370734;
    in_valid = 1;
    exp_q.push_back(model_enc(in_data));
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      in_valid = 0;
      if (c == 9) begin
        n_tests++;
        if ({round_key_addr, round_key_input} !== {4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6}) begin
          n_fail++; $display("FAIL appb_rk10 got addr=%0d key=%h", round_key_addr, round_key_input);
        end
      end
      if (out_valid) break;
    end
    n_tests++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL appb_timeout got out_valid=%b exp=1", out_valid); end
    n_tests++;
    if (out_data !== 128'h3925841d02dc09fbdc118597196a0b32) begin n_fail++; $display("FAIL appb_vector got=%h exp=3925841d02dc09fbdc118597196a0b32", out_data); end
    n_tests++;
    if (exp_q.size() == 0 || out_data !== exp_q[0]) begin n_fail++; $display("FAIL appb_scoreboard got=%h", out_data); end
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if ({out_valid, in_ready, busy, out_data} !== {3'b101, held}) begin
        n_fail++; $display("FAIL stall_hold cycle %0d got vld/rdy/busy=%b data=%h exp=101 %h", i, {out_valid, in_ready, busy}, out_data, held);
      end
    end
    out_ready = 1;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    @(negedge clk);
    out_ready = 0;
    n_tests++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin n_fail++; $display("FAIL stall_release got vld/rdy/busy=%b exp=010", {out_valid, in_ready, busy}); end
  endtask

  task automatic test_input_while_busy();
    logic [127:0] a = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] b = {$urandom, $urandom, $urandom, $urandom};
    int acc = 0, got = 0, t0 = 0, t1 = 0;
    set_key(K_C1);
    out_ready = 1;
    for (int c = 0; c < 80 && got < 2; c++) begin
      if (out_valid) begin
        n_tests++;
        if (exp_q.size() == 0 || out_data !== exp_q[0]) begin n_fail++; $display("FAIL busy_out %0d got=%h", got, out_data); end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        got++;
      end
      if (acc < 2) begin
        in_valid = 1;
        in_data = (acc == 0) ? a : b;
        if (in_ready) begin
          exp_q.push_back(model_enc(in_data));
          if (acc == 0) t0 = c; else t1 = c;
          acc++;
        end
      end else in_valid = 0;
      @(negedge clk);
    end
    in_valid = 0;
    n_tests++;
    if (got != 2 || exp_q.size() != 0) begin n_fail++; $display("FAIL busy_count got=%0d left=%0d exp=2 0", got, exp_q.size()); end
    n_tests++;
    if (t1 - t0 < 12) begin n_fail++; $display("FAIL busy_gap got=%0d exp>=12", t1 - t0); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_round();
    set_key(K_C1);
    in_data = P_C1;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    for (int c = 0; c < 20; c++) begin
      if (round_key_addr == 4'd5) break;
      @(negedge clk);
    end
    n_tests++;
    if (round_key_addr !== 4'd5) begin n_fail++; $display("FAIL rst_reach_round5 got=%0d exp=5", round_key_addr); end
    rst = 1;
    #1;
    n_tests++;
    if ({in_ready, out_valid, busy, round_key_addr, out_data} !== {3'b100, 4'd0, 128'd0}) begin
      n_fail++;
      $display("FAIL rst_mid_round got rdy=%b vld=%b busy=%b addr=%0d data=%h", in_ready, out_valid, busy, round_key_addr, out_data);
    end
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    out_ready = 1;
    in_valid = 1;
    exp_q.push_back(model_enc(P_C1));
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      in_valid = 0;
      if (out_valid) break;
    end
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== C_C1) begin n_fail++; $display("FAIL rst_recover got vld=%b data=%h exp=1 %h", out_valid, out_data, C_C1); end
    n_tests++;
    if (exp_q.size() == 0 || out_data !== exp_q[0]) begin n_fail++; $display("FAIL rst_recover_sb got=%h", out_data); end
    exp_q.delete();
    @(negedge clk);
    out_ready = 0;
  endtask

  task automatic test_back_to_back();
    logic [127:0] keys [4];
    logic [127:0] pts [4];
    int sent = 0, got = 0;
    for (int i = 0; i < 4; i++) begin
      keys[i] = {$urandom, $urandom, $urandom, $urandom};
      pts[i]  = {$urandom, $urandom, $urandom, $urandom};
    end
    for (int c = 0; c < 400 && got < 4; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        n_tests++;
        if (exp_q.size() == 0 || out_data !== exp_q[0]) begin n_fail++; $display("FAIL stream_out %0d got=%h", got, out_data); end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        got++;
      end
      if (sent < 4 && in_ready) begin
        set_key(keys[sent]);
        in_data = pts[sent];
        in_valid = 1;
        exp_q.push_back(model_enc(pts[sent]));
        sent++;
      end else in_valid = 0;
      @(negedge clk);
    end
    in_valid = 0;
    out_ready = 0;
    n_tests++;
    if (got != 4 || exp_q.size() != 0) begin n_fail++; $display("FAIL stream_count got=%0d left=%0d exp=4 0", got, exp_q.size()); end
  endtask

  initial begin
    init_sbox();
    set_key(128'd0);
    test_reset();
    test_fips_c1();
    test_backpressure();
    test_input_while_busy();
    test_reset_mid_round();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
